// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, default bit timing and parity helper
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } uart_state_e;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;

   // Frames narrower than 8 bits are zero-extended, which leaves the XOR unchanged.
   function automatic logic calc_parity(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser with asynchronous reset to RESET_VAL
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: synchronise rx, mid-bit sampling, one-cycle result strobes
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         perr_q       <= perr_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            bit_d  = '0;
            perr_d = 1'b0;
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            // A start bit that is high again at its midpoint is a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
         ST_PARITY: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               perr_d  = rx_s != calc_parity(8'(shift_q), PARITY_ODD != 0);
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_s) state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   always_comb begin
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      if (enable && state_q == ST_STOP && cnt_q == CNT_FULL) begin
         if (!rx_s) begin
            frame_err_d = 1'b1;
         end else if (perr_q) begin
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b1;
`endif
         end else begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
         end
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign busy       = state_q != ST_IDLE;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - table-driven bench for uart_rx at 16 clocks per bit, 8 data bits
module tb_uart_rx;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int LAT = (CPB * 3) / 2 + (8 + PBITS) * CPB + 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_ferr = 0;
   int n_perr = 0;
   int last_valid_cyc = 0;
   int pulse_viol = 0;
   int data_viol = 0;
   int busy_viol = 0;
   int fall_cyc = 0;
   logic [7:0] prev_data = 8'h00;
   logic prev_pulse = 1'b0;
   bit busy_watch = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         hold_low;
      int         gap;
      logic [7:0] exp_data;
      int         exp_valid;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[5];

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_ODD(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         prev_pulse <= 1'b0;
         prev_data  <= rx_data;
      end else begin
         if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) pulse_viol <= pulse_viol + 1;
         if ((rx_valid | frame_err | parity_err) && prev_pulse) pulse_viol <= pulse_viol + 1;
         if (rx_data != prev_data && !rx_valid) data_viol <= data_viol + 1;
         if (rx_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
         end
         if (frame_err) n_ferr <= n_ferr + 1;
         if (parity_err) n_perr <= n_perr + 1;
         prev_pulse <= rx_valid | frame_err | parity_err;
         prev_data  <= rx_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Called at posedge+1; holds rx for one bit period and ends at posedge+1.
   task automatic send_bit(input logic v);
      rx = v;
      repeat (CPB / 2) @(posedge clk);
      @(negedge clk);
      if (busy_watch && !busy) busy_viol++;
      repeat (CPB / 2) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop, input logic bad_par);
      logic par;
      par = (^data) ^ bad_par;
      fall_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      if (PBITS == 1) send_bit(par);
      send_bit(stop);
   endtask

   initial begin
      int v0, f0, p0;
      logic [7:0] held;

      vecs[0] = '{8'h3C, 1'b1, 0, 16, 8'h3C, 1, 0};
      vecs[1] = '{8'hA5, 1'b1, 0, 16, 8'hA5, 1, 0};
      vecs[2] = '{8'h81, 1'b0, 40, 16, 8'hA5, 0, 1};
      vecs[3] = '{8'h00, 1'b1, 0, 0, 8'h00, 1, 0};
      vecs[4] = '{8'hFF, 1'b1, 0, 16, 8'hFF, 1, 0};

      rst = 1'b1;
      enable = 1'b1;
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_parity_err", parity_err, 1'b0);
      check("reset_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Short low pulse: start detected, then rejected at the start-bit midpoint.
      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("glitch_detect_busy", busy, 1'b1);
      @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("glitch_back_idle", busy, 1'b0);
      check("glitch_no_valid", n_valid - v0, 0);
      check("glitch_no_ferr", n_ferr - f0, 0);
      check("glitch_no_perr", n_perr - p0, 0);
      repeat (16) @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) begin
         v0 = n_valid; f0 = n_ferr; p0 = n_perr;
         busy_watch = 1'b1;
         send_frame(vecs[i].data, vecs[i].stop, 1'b0);
         busy_watch = 1'b0;
         if (vecs[i].hold_low > 0) begin
            rx = 1'b0;
            repeat (vecs[i].hold_low) @(posedge clk);
            @(negedge clk);
            check("break_busy_wait_high", busy, 1'b1);
            check("break_no_retrigger", n_valid - v0, 0);
            rx = 1'b1;
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("break_exit_idle", busy, 1'b0);
            @(posedge clk);
            #1;
         end
         check($sformatf("vec%0d_valid_count", i), n_valid - v0, vecs[i].exp_valid);
         check($sformatf("vec%0d_ferr_count", i), n_ferr - f0, vecs[i].exp_ferr);
         check($sformatf("vec%0d_perr_count", i), n_perr - p0, 0);
         check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
         if (vecs[i].exp_valid == 1)
            check_range($sformatf("vec%0d_latency", i), last_valid_cyc - fall_cyc, LAT - 2, LAT + 2);
         if (vecs[i].gap > 0) begin
            repeat (vecs[i].gap) @(posedge clk);
            #1;
         end
      end

      // Receiver disabled mid-frame: abort without pulses, data held.
      v0 = n_valid; f0 = n_ferr; held = rx_data;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge clk);
      check("enable_busy_before", busy, 1'b1);
      @(posedge clk);
      #1;
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("enable_abort_idle", busy, 1'b0);
      @(posedge clk);
      #1;
      for (int b = 0; b < 6; b++) send_bit(1'b0);
      send_bit(1'b1);
      enable = 1'b1;
      repeat (CPB) @(posedge clk);
      #1;
      check("enable_no_valid", n_valid - v0, 0);
      check("enable_no_ferr", n_ferr - f0, 0);
      check("enable_data_held", rx_data, held);

      // Asynchronous reset during data bit 3, then a fresh frame.
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rx = 1'b1;
      repeat (CPB / 2) @(posedge clk);
      @(negedge clk);
      check("rst_busy_before", busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_busy", busy, 1'b0);
      check("rst_async_rx_data", rx_data, 8'h00);
      check("rst_async_rx_valid", rx_valid, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2 * CPB) @(posedge clk);
      #1;
      v0 = n_valid;
      send_frame(8'h5A, 1'b1, 1'b0);
      check("post_rst_valid_count", n_valid - v0, 1);
      check("post_rst_rx_data", rx_data, 8'h5A);
      repeat (CPB) @(posedge clk);
      #1;

`ifdef UART_RX_PARITY_EN
      v0 = n_valid; p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b0);
      check("par_good_valid", n_valid - v0, 1);
      check("par_good_perr", n_perr - p0, 0);
      check("par_good_data", rx_data, 8'h07);
      repeat (CPB) @(posedge clk);
      #1;
      v0 = n_valid; p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b1);
      check("par_bad_valid", n_valid - v0, 0);
      check("par_bad_perr", n_perr - p0, 1);
      check("par_bad_data_held", rx_data, 8'h07);
      repeat (CPB) @(posedge clk);
      #1;
`endif

      check("pulse_exclusive_single", pulse_viol, 0);
      check("rx_data_only_with_valid", data_viol, 0);
      check("busy_during_frames", busy_viol, 0);
      check("parity_err_total", n_perr, PBITS);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the single-cycle RISC-V UART peripheral; the receive-side counterpart of the tx output path.
- Synchronises the asynchronous rx line and detects start bits.
- Samples each bit at its midpoint, then presents one assembled byte with a one-cycle valid strobe to the core's UART register block.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per bit period (50 MHz / 9600 baud); legal range 4 to 65535.
- DATA_BITS, 8: data bits per frame, sent LSB first; legal range 5 to 8.
- PARITY_ODD, 0: parity sense, used only when UART_RX_PARITY_EN is defined; 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  receiver enable; while low the FSM is forced to IDLE.
- rx  input  1  serial line, asynchronous, idle high.
- rx_data  output  DATA_BITS  last received byte; holds its value between frames.
- rx_valid  output  1  one-cycle pulse when rx_data is updated with a good frame.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when the feature is compiled out.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: all of the following go to their reset values.
  - rx_data = 0; rx_valid, frame_err, parity_err, busy = 0.
  - State = IDLE; counters = 0.
  - Synchroniser flops = 1, so no false start bit is seen after reset.
- Synchroniser: two flops on rx, giving rx_s. All decisions use rx_s only; this adds 2 cycles of latency.
- States:
  - IDLE: when enable = 1 and rx_s = 0, clear the cycle counter and go to START.
  - START: at count CLKS_PER_BIT/2 - 1 (integer divide), sample rx_s.
    - If 0, clear counter and go to DATA.
    - If 1, treat as a glitch and return to IDLE with no outputs.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit index k, for k = 0..DATA_BITS-1. After the last bit, go to PARITY (feature on) or STOP.
  - PARITY: one bit period later, sample and compare, then go to STOP.
  - STOP: one bit period later, sample rx_s.
    - If 1 and no parity error: load rx_data, pulse rx_valid, go to IDLE.
    - If 1 with a parity error: pulse parity_err only, go to IDLE.
    - If 0: pulse frame_err, leave rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: remain here until rx_s = 1, then go to IDLE. This prevents a break condition from re-triggering reception.
- Latency: rx_valid rises in the cycle after the stop-bit mid-sample. That is about (1.5 + DATA_BITS [+1 parity]) × CLKS_PER_BIT + 3 cycles after the rx falling edge.
- Output pulses: rx_valid, frame_err and parity_err are mutually exclusive and last exactly one cycle. rx_data changes only on the same cycle as rx_valid.
- Back-to-back frames: a start edge in the cycle immediately after the STOP→IDLE transition is accepted; no extra idle time is required.
- enable deasserted mid-frame: abort in the next cycle to IDLE. No pulses; rx_data is unchanged.
- Asynchronous reset mid-frame: immediate return to reset values.
- Counter width: $clog2(CLKS_PER_BIT). Bit counter width: $clog2(DATA_BITS+1).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA.
  - Expected parity = XOR of the data bits, inverted when PARITY_ODD = 1.
  - On mismatch, parity_err is pulsed and rx_valid is suppressed.
- Undefined:
  - No PARITY state; frame = start + DATA_BITS + stop.
  - parity_err is tied to 0.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - default CLKS_PER_BIT;
  - the parity-compute function, reused by the tx side.
- One sub-module, sync_2ff: 1-bit two-flop synchroniser with asynchronous, active-high reset to a parameterised value (here 1).

Test Plan (CLKS_PER_BIT = 16, DATA_BITS = 8):
- Frame 0xA5, 8N1 → rx_data = 0xA5; a single rx_valid pulse 155 ± 2 cycles after the falling edge; busy high throughout the frame.
- rx low for 5 cycles, then high → no pulses; FSM back in IDLE by cycle 10; a following frame of 0x3C is received correctly.
- Frame 0x81 with stop bit = 0, line held low for 40 cycles → frame_err pulses once, rx_data stays 0xA5, no re-trigger until the line goes high.
- Back-to-back frames 0x00 and 0xFF with zero idle gap → two rx_valid pulses, rx_data = 0x00 then 0xFF.
- Asynchronous rst asserted during DATA bit 3, then a fresh 0x5A frame → outputs are 0 immediately on reset; 0x5A then received correctly.
- With UART_RX_PARITY_EN defined and PARITY_ODD = 0:
  - 0x07 with parity bit 1 → rx_valid.
  - 0x07 with parity bit 0 → parity_err pulse, no rx_valid.
